// File: rtl/vermibus_pkg.sv
// vermibus_pkg: shared Vermibus widths, request bundle and arbiter state type
package vermibus_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [STRB_W-1:0] wstrobe;
        logic [DATA_W-1:0] wdata;
    } vermibus_req_t;

    typedef enum bit { ARB_IDLE, ARB_BUSY } arb_state_t;
endpackage

// File: rtl/vermibus_rr_pick.sv
// vermibus_rr_pick: two-way round-robin picker favouring the initiator not served last
module vermibus_rr_pick (
    input  logic [1:0] req,
    input  logic       last,
    output logic       sel
);
    assign sel = &req ? ~last : req[1];
endmodule

// File: rtl/vermibus_arbiter.sv
// vermibus_arbiter: round-robin two-initiator to one-responder Vermibus arbiter with transaction lock
module vermibus_arbiter
    import vermibus_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_valid,
    input  logic [ADDR_W-1:0] m0_address,
    input  logic [STRB_W-1:0] m0_wstrobe,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    output logic              m0_irq,
    input  logic              m1_valid,
    input  logic [ADDR_W-1:0] m1_address,
    input  logic [STRB_W-1:0] m1_wstrobe,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              m1_irq,
    output logic              s_valid,
    output logic [ADDR_W-1:0] s_address,
    output logic [STRB_W-1:0] s_wstrobe,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    input  logic              s_irq
);
    arb_state_t    state, state_n;
    logic          owner, owner_n, last, last_n, pick, sel, sel_d;
    vermibus_req_t req0, req1, s_req;

    vermibus_rr_pick u_pick (
        .req  ({m1_valid, m0_valid}),
        .last (last),
        .sel  (pick)
    );

    assign sel   = (state == ARB_BUSY || !(m0_valid | m1_valid)) ? owner : pick;
    // during reset the datapath parks on initiator 0 and all handshakes are masked
    assign sel_d = reset & sel;
    assign req0  = '{address: m0_address, wstrobe: m0_wstrobe, wdata: m0_wdata};
    assign req1  = '{address: m1_address, wstrobe: m1_wstrobe, wdata: m1_wdata};
    assign s_req = sel_d ? req1 : req0;

    assign s_valid   = reset & (sel_d ? m1_valid : m0_valid);
    assign s_address = s_req.address;
    assign s_wstrobe = s_req.wstrobe;
    assign s_wdata   = s_req.wdata;
    assign m0_ready  = s_ready & s_valid & ~sel_d;
    assign m1_ready  = s_ready & s_valid & sel_d;
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_irq    = s_irq;
    assign m1_irq    = 1'b0;

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        if (state == ARB_IDLE) begin
            if (s_valid & ~s_ready) begin
                state_n = ARB_BUSY;
                owner_n = sel;
            end else if (s_valid) begin
                last_n = sel;
            end
        end else if (s_ready) begin
            state_n = ARB_IDLE;
            last_n  = owner;
        end else if (!s_valid) begin
            state_n = ARB_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB_IDLE;
            owner <= 1'b0;
            last  <= 1'b1;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
        end
    end
endmodule

// File: tb/tb_vermibus_arbiter.sv
// tb_vermibus_arbiter: directed-vector self-checking bench for vermibus_arbiter
module tb_vermibus_arbiter;
    logic        clk = 0, reset = 0;
    logic        m0_valid = 0, m1_valid = 0, s_ready = 0, s_irq = 0;
    logic [31:0] m0_address = 0, m1_address = 0, m0_wdata = 0, m1_wdata = 0, s_rdata = 0;
    logic [3:0]  m0_wstrobe = 0, m1_wstrobe = 0;
    logic [31:0] m0_rdata, m1_rdata, s_address, s_wdata;
    logic [3:0]  s_wstrobe;
    logic        m0_ready, m1_ready, m0_irq, m1_irq, s_valid;
    int          checks = 0, errors = 0;

    localparam logic [31:0] A0 = 32'h0000_0a00, A1 = 32'h0000_0b00;

    vermibus_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_address(m0_address), .m0_wstrobe(m0_wstrobe), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready), .m0_irq(m0_irq),
        .m1_valid(m1_valid), .m1_address(m1_address), .m1_wstrobe(m1_wstrobe), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready), .m1_irq(m1_irq),
        .s_valid(s_valid), .s_address(s_address), .s_wstrobe(s_wstrobe), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready), .s_irq(s_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v0, input logic [31:0] a0, input logic v1, input logic [31:0] a1,
                         input logic sr);
        m0_valid = v0; m0_address = a0; m1_valid = v1; m1_address = a1; s_ready = sr;
        @(negedge clk);
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic grant(input string tag, input logic sv, input logic [31:0] addr,
                         input logic r0, input logic r1);
        check({tag, " s_valid"}, 32'(s_valid), 32'(sv));
        check({tag, " s_address"}, s_address, addr);
        check({tag, " m0_ready"}, 32'(m0_ready), 32'(r0));
        check({tag, " m1_ready"}, 32'(m1_ready), 32'(r1));
    endtask

    task automatic do_reset;
        reset = 0;
        drive(1, A0, 1, A1, 1);
        next();
        reset = 1;
    endtask

    initial begin
        #1;
        s_irq = 1;
        drive(1, A0, 1, A1, 1);
        grant("reset", 0, A0, 0, 0);
        check("m0_irq", 32'(m0_irq), 1);
        check("m1_irq", 32'(m1_irq), 0);
        s_irq = 0;
        next();
        reset = 1;

        s_rdata = 32'hDEADBEEF;
        drive(1, 32'h10, 0, 0, 1);
        grant("zw read", 1, 32'h10, 1, 0);
        check("zw rdata", m0_rdata, 32'hDEADBEEF);
        check("zw m1_rdata", m1_rdata, 32'hDEADBEEF);
        next();
        drive(0, 32'h10, 1, 32'h20, 0);
        grant("zw nolock", 1, 32'h20, 0, 0);
        next();

        do_reset();
        m0_wstrobe = 4'hF; m0_wdata = 32'h1111_2222; m1_wstrobe = 4'h3; m1_wdata = 32'h3333_4444;
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h8000_0000, 1, 32'h8100_0000, i == 2);
            grant($sformatf("sim m0 c%0d", i), 1, 32'h8000_0000, i == 2, 0);
            check("sim wstrobe", 32'(s_wstrobe), 32'hF);
            check("sim wdata", s_wdata, 32'h1111_2222);
            next();
        end
        drive(0, 32'h8000_0000, 1, 32'h8100_0000, 1);
        grant("sim m1", 1, 32'h8100_0000, 0, 1);
        check("sim m1 wstrobe", 32'(s_wstrobe), 32'h3);
        check("sim m1 wdata", s_wdata, 32'h3333_4444);
        next();
        m0_wstrobe = 0; m1_wstrobe = 0;

        for (int i = 0; i < 8; i++) begin
            drive(1, A0, 1, A1, 1);
            grant($sformatf("rr t%0d", i), 1, i % 2 ? A1 : A0, i % 2 == 0, i % 2 == 1);
            next();
        end

        for (int i = 0; i < 4; i++) begin
            drive(i > 0, A0, 1, A1, i == 3);
            grant($sformatf("lock c%0d", i), 1, A1, 0, i == 3);
            next();
        end
        drive(1, A0, 1, A1, 1);
        grant("lock after", 1, A0, 1, 0);
        next();

        drive(0, A0, 1, A1, 0);
        grant("rst busy", 1, A1, 0, 0);
        next();
        reset = 0;
        drive(1, A0, 1, A1, 1);
        grant("rst mid", 0, A0, 0, 0);
        next();
        reset = 1;
        drive(1, A0, 1, A1, 0);
        grant("rst release", 1, A0, 0, 0);
        next();
        drive(1, A0, 1, A1, 1);
        grant("rst done", 1, A0, 1, 0);
        next();

        drive(0, A0, 1, A1, 0);
        grant("abandon lock", 1, A1, 0, 0);
        next();
        drive(1, A0, 0, A1, 0);
        grant("abandon drop", 0, A1, 0, 0);
        next();
        drive(1, A0, 0, A1, 1);
        grant("abandon m0", 1, A0, 1, 0);
        next();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
